present_byte_stream: RTL and testbench
======================================

# present_byte_stream

Byte-serial streaming front/back end for the `present` cipher core. It gathers eight input bytes into one 64-bit block and runs that block through the core's encrypt or decrypt path. It then returns the 64-bit result as eight output bytes. Upstream, the producer uses a valid/ready byte interface. Downstream, the block drives the core's `block_i`, `enc_dec` and start/level control and consumes `block_o`, `end_enc`/`end_dec` and `end_key_generation`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `mode`  in  1  0 = encrypt, 1 = decrypt; sampled with the first byte of a block.
- `iv`  in  64  CBC initial vector.
- `iv_load`  in  1  one-cycle pulse; loads `iv` into the chain register.
- `in_data`  in  8  input byte, MSB-first within the block.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a byte.
- `out_data`  out  8  output byte, MSB-first.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts a byte.
- `busy`  out  1  high outside IDLE/COLLECT with zero bytes held.
- `abort`  out  1  one-cycle pulse when an operation is dropped.
- `core_key_ready`  in  1  core key schedule finished (`end_key_generation`).
- `core_start`  out  1  level; high runs the core, low holds the core counters cleared.
- `core_enc_dec`  out  1  core direction, equals the latched `mode`.
- `core_block`  out  64  core input block.
- `core_result`  in  64  core output block.
- `core_done`  in  1  `end_enc`/`end_dec` of the selected direction.

## Operation
- States: IDLE, COLLECT, RUN, RELEASE, EMIT.
- IDLE: `in_ready`=0. Go to COLLECT when `core_key_ready`=1.
- COLLECT: `in_ready`=1.
  - On each handshake (`in_valid & in_ready`): `blk <= {blk[55:0], in_data}` and the 3-bit `cnt` increments.
  - `mode` is latched when `cnt`=0.
  - When `cnt`=7 and a handshake occurs, `cnt` wraps to 0 and the state moves to RUN.
- RUN: `core_start`=1 and `core_block` is held stable.
  - When `core_done`=1, capture the result into `obuf` and go to RELEASE.
- RELEASE: `core_start`=0 for exactly one cycle, then go to EMIT.
- EMIT: `out_valid`=1 and `out_data`=`obuf[63:56]`.
  - On each handshake: `obuf <= {obuf[55:0], 8'h00}` and `cnt` increments.
  - After the 8th handshake, go to COLLECT.
- Input and output phases never overlap. `in_ready`=0 in RUN, RELEASE and EMIT.
- If `core_key_ready` falls in any state other than IDLE:
  - return to IDLE next cycle, clear `cnt`, drop `core_start`;
  - pulse `abort` for one cycle;
  - discard the partial block and any unsent bytes.
- `iv_load` is honoured in any state. If it coincides with a chain update, `iv_load` wins.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `core_start`=0, `core_enc_dec`=0, `core_block`=0, `busy`=0, `abort`=0. Internal `blk`, `obuf`, chain and `cnt` reset to 0. State resets to IDLE.
- Latency:
  - The 8th input handshake at cycle N gives `core_start`=1 at N+1.
  - `core_done` seen at cycle M gives the first `out_valid` at M+2.
- Core run time is set by the core (about 32 cycles). The block imposes no timeout.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Back-to-back blocks are allowed: COLLECT is re-entered the cycle after the 8th output handshake.
- Reset asserted mid-operation clears everything immediately, with no `abort` pulse.

## Configuration
- Macro: `PRESENT_STREAM_CBC_EN`.
- Defined: CBC chaining is enabled.
  - Encrypt: `core_block = blk ^ chain`; on capture, `obuf = core_result` and `chain <= core_result`.
  - Decrypt: `core_block = blk`; on capture, `obuf = core_result ^ chain` and `chain <= blk`.
- Undefined: ECB mode.
  - `core_block = blk` and `obuf = core_result`.
  - The chain register is absent, and `iv`/`iv_load` are ignored.

## Test plan
- ECB encrypt: key 0, bytes 00×8, `mode`=0. Output bytes 55 79 C1 38 7B 22 84 45, `abort` never pulses.
- ECB decrypt: key 0, bytes 55 79 C1 38 7B 22 84 45, `mode`=1. Output 00×8.
- Output back-pressure: `out_ready`=0 for 5 cycles on byte 3. `out_data` is held, no byte is lost or duplicated, `in_ready` stays 0.
- Key drop mid-block: 4 bytes accepted, then `core_key_ready`=0. `abort` pulses once and the next 8 bytes after key ready produce the correct ECB ciphertext.
- CBC (macro defined): `iv`=0, two blocks of 00×8 encrypted. First output 5579C1387B228445; second output equals the model's PRESENT(key 0, 5579C1387B228445). Decrypting both restores 00×16.
- Back-to-back: 3 consecutive blocks with `in_valid`/`out_ready` tied high. Each block's first output comes 2 cycles after its `core_done`, and no bubbles exceed the RELEASE cycle.

Source files
------------

// File: rtl/present_byte_stream.sv
// Byte-serial valid/ready front/back end for a PRESENT cipher core.
// Define PRESENT_STREAM_CBC_EN for CBC chaining; the default build is ECB.
module present_byte_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [63:0] iv,
  input  logic        iv_load,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        abort,
  input  logic        core_key_ready,
  output logic        core_start,
  output logic        core_enc_dec,
  output logic [63:0] core_block,
  input  logic [63:0] core_result,
  input  logic        core_done
);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StRun,
    StRelease,
    StEmit
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] blk_q, blk_d;
  logic [63:0] obuf_q, obuf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        abort_q, abort_d;

  logic        key_lost;
  logic        capture_en;
  logic [63:0] capture;

  // Losing the key schedule outside IDLE drops whatever is in flight.
  assign key_lost   = (state_q != StIdle) & ~core_key_ready;
  assign capture_en = (state_q == StRun) & core_done & ~key_lost;

`ifdef PRESENT_STREAM_CBC_EN
  logic [63:0] chain_q, chain_d;

  always_comb begin
    core_block = mode_q ? blk_q : (blk_q ^ chain_q);
    capture    = mode_q ? (core_result ^ chain_q) : core_result;
  end

  // iv_load has priority over the chain update from a finished block.
  always_comb begin
    chain_d = chain_q;
    if (iv_load) begin
      chain_d = iv;
    end else if (capture_en) begin
      chain_d = mode_q ? blk_q : core_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= 64'h0;
    end else begin
      chain_q <= chain_d;
    end
  end
`else
  logic unused_iv;

  assign unused_iv  = ^{iv, iv_load};
  assign core_block = blk_q;
  assign capture    = core_result;
`endif

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    obuf_d     = obuf_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    abort_d    = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    core_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (core_key_ready) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d = {blk_q[55:0], in_data};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) begin
            mode_d = mode;
          end
          if (cnt_q == 3'd7) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        core_start = 1'b1;
        if (capture_en) begin
          obuf_d  = capture;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // One cycle with core_start low re-arms the core counters.
        state_d = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        out_data  = obuf_q[63:56];
        if (out_ready) begin
          obuf_d = {obuf_q[55:0], 8'h00};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = StCollect;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (key_lost) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      blk_d   = 64'h0;
      obuf_d  = 64'h0;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      blk_q   <= 64'h0;
      obuf_q  <= 64'h0;
      cnt_q   <= 3'd0;
      mode_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      obuf_q  <= obuf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      abort_q <= abort_d;
    end
  end

  assign abort        = abort_q;
  assign core_enc_dec = mode_q;
  assign busy         = ~((state_q == StIdle) | ((state_q == StCollect) & (cnt_q == 3'd0)));

endmodule

// File: tb/tb_present_byte_stream.sv
// Self-checking bench for present_byte_stream with a behavioural PRESENT-80 core stand-in.
// Honours PRESENT_STREAM_CBC_EN so the reference model chains when the DUT does.
`timescale 1ns/1ps
module tb_present_byte_stream;

  localparam int          Lat   = 32;
  localparam int          Bound = 200;
  localparam logic [79:0] Key   = 80'h0;
`ifdef PRESENT_STREAM_CBC_EN
  localparam bit Cbc = 1'b1;
`else
  localparam bit Cbc = 1'b0;
`endif

  logic        clk, rst, mode, iv_load, in_valid, in_ready, out_valid, out_ready;
  logic        busy, abort, core_key_ready, core_start, core_enc_dec, core_done;
  logic [63:0] iv, core_block, core_result;
  logic [7:0]  in_data, out_data;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          abort_cnt = 0;
  logic [63:0] chain_m = 64'h0;

  present_byte_stream dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .iv             (iv),
    .iv_load        (iv_load),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .abort          (abort),
    .core_key_ready (core_key_ready),
    .core_start     (core_start),
    .core_enc_dec   (core_enc_dec),
    .core_block     (core_block),
    .core_result    (core_result),
    .core_done      (core_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x, input bit inv);
    logic [63:0] t;
    t = inv ? 64'hA970364BD21C8FE5 : 64'h21748FE3DA09B65C;
    return t[4*x +: 4];
  endfunction

  function automatic logic [63:0] sub_layer(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    for (int i = 0; i < 16; i++) t[4*i +: 4] = sb(s[4*i +: 4], inv);
    return t;
  endfunction

  function automatic logic [63:0] perm_layer(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    int p;
    for (int i = 0; i < 64; i++) begin
      p = (i == 63) ? 63 : (i * 16) % 63;
      if (!inv) t[p] = s[i];
      else      t[i] = s[p];
    end
    return t;
  endfunction

  function automatic logic [63:0] present(input logic dec, input logic [63:0] d);
    logic [79:0] k;
    logic [63:0] rk [33];
    logic [63:0] s;
    k = Key;
    for (int r = 1; r <= 32; r++) begin
      rk[r]     = k[79:16];
      k         = {k[18:0], k[79:19]};
      k[79:76]  = sb(k[79:76], 1'b0);
      k[19:15]  = k[19:15] ^ 5'(r);
    end
    if (!dec) begin
      s = d;
      for (int r = 1; r <= 31; r++) s = perm_layer(sub_layer(s ^ rk[r], 1'b0), 1'b0);
      s = s ^ rk[32];
    end else begin
      s = d ^ rk[32];
      for (int r = 31; r >= 1; r--) s = sub_layer(perm_layer(s, 1'b1), 1'b1) ^ rk[r];
    end
    return s;
  endfunction

  // Stream-level model: what the eight output bytes of a block must be.
  task automatic model_step(input logic m, input logic [63:0] d, output logic [63:0] r);
    if (!Cbc) begin
      r = present(m, d);
    end else if (!m) begin
      r       = present(1'b0, d ^ chain_m);
      chain_m = r;
    end else begin
      r       = present(1'b1, d) ^ chain_m;
      chain_m = d;
    end
  endtask

  // Core stand-in: counts while core_start is high, answers after Lat cycles.
  int ccnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccnt        <= 0;
      core_done   <= 1'b0;
      core_result <= 64'h0;
    end else if (!core_start) begin
      ccnt      <= 0;
      core_done <= 1'b0;
    end else begin
      ccnt      <= ccnt + 1;
      core_done <= (ccnt == Lat - 1);
      if (ccnt == Lat - 1) core_result <= present(core_enc_dec, core_block);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------- timing monitor ----------------
  int cyc = 0, in_n = 0, out_n = 0, exp_start = -1, exp_ov = -1, exp_ir = -1;
  bit prev_ov = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        in_n = 0; out_n = 0; exp_start = -1; exp_ov = -1; exp_ir = -1; prev_ov = 1'b0;
      end else begin
        if (abort) abort_cnt++;
        if (cyc == exp_start) check("start_latency", 64'(core_start), 64'd1);
        if (out_valid && !prev_ov) check("first_out_cycle", 64'(cyc), 64'(exp_ov));
        if (cyc == exp_ir) check("collect_reentry", 64'(in_ready), 64'd1);
        if (out_valid) check("no_io_overlap", 64'(in_ready), 64'd0);
        if (!core_key_ready) begin
          in_n = 0; out_n = 0;
        end else begin
          if (in_valid && in_ready) begin
            in_n++;
            if (in_n == 8) begin in_n = 0; exp_start = cyc + 1; end
          end
          if (core_done && core_start) exp_ov = cyc + 2;
          if (out_valid && out_ready) begin
            out_n++;
            if (out_n == 8) begin out_n = 0; exp_ir = cyc + 1; end
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- drivers (inputs change 1ns after posedge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic m, input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    mode     = m;
    for (int n = 0; n < Bound && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    check("in_handshake_in_time", 64'(ok), 64'd1);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    bit ok = 1'b0;
    b         = 8'h00;
    out_ready = 1'b1;
    for (int n = 0; n < Bound && !ok; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        b  = out_data;
      end
      tick();
    end
    check("out_handshake_in_time", 64'(ok), 64'd1);
  endtask

  task automatic send_block(input logic m, input logic [63:0] d);
    for (int i = 0; i < 8; i++) send_byte(m, d[63-8*i -: 8]);
    in_valid = 1'b0;
  endtask

  task automatic recv_block(output logic [63:0] r);
    logic [7:0] b;
    r = 64'h0;
    for (int i = 0; i < 8; i++) begin
      recv_byte(b);
      r = {r[55:0], b};
    end
  endtask

  task automatic run_block(input string name, input logic m, input logic [63:0] d);
    logic [63:0] exp, got;
    model_step(m, d, exp);
    send_block(m, d);
    recv_block(got);
    check(name, got, exp);
  endtask

  task automatic pulse_iv(input logic [63:0] v);
    iv      = v;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    chain_m = v;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        m;
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  vec_t        tbl [4];
  logic [63:0] bd [3], bexp [3], bgot [3];

  initial begin
    logic [63:0] exp, got, d;
    logic [7:0]  b;
    int          a0;

    tbl[0] = '{1'b0, 64'h0000000000000000, 64'h5579C1387B228445};
    tbl[1] = '{1'b1, 64'h5579C1387B228445, 64'h0000000000000000};
    tbl[2] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hA112FFC72F68417B};
    tbl[3] = '{1'b1, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF};

    rst = 1'b0; mode = 1'b0; iv = 64'h0; iv_load = 1'b0; in_data = 8'h00;
    in_valid = 1'b0; out_ready = 1'b0; core_key_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_enc_dec", 64'(core_enc_dec), 64'd0);
    check("rst_core_block", core_block, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("idle_without_key", 64'(in_ready), 64'd0);
    tick();
    core_key_ready = 1'b1;
    tick();
    @(negedge clk);
    check("collect_after_key", 64'(in_ready), 64'd1);
    check("collect_empty_not_busy", 64'(busy), 64'd0);
    tick();

    // Published PRESENT-80 vectors; zero IV makes CBC collapse to ECB.
    for (int i = 0; i < 4; i++) begin
      pulse_iv(64'h0);
      model_step(tbl[i].m, tbl[i].din, exp);
      send_block(tbl[i].m, tbl[i].din);
      recv_block(got);
      check($sformatf("vector%0d", i), got, tbl[i].dout);
    end
    check("no_abort_in_vectors", 64'(abort_cnt), 64'd0);

    // Output back-pressure on byte 3.
    pulse_iv(64'h0);
    d = 64'h0123456789ABCDEF;
    model_step(1'b0, d, exp);
    send_block(1'b0, d);
    got = 64'h0;
    for (int i = 0; i < 3; i++) begin
      recv_byte(b);
      got = {got[55:0], b};
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_data_held", 64'(out_data), 64'(exp[39:32]));
      check("stall_valid_held", 64'(out_valid), 64'd1);
      check("stall_in_ready_low", 64'(in_ready), 64'd0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      recv_byte(b);
      got = {got[55:0], b};
    end
    check("stall_block", got, exp);

    // Key drop after 4 accepted bytes.
    pulse_iv(64'h0);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'hA5);
    in_valid = 1'b0;
    a0 = abort_cnt;
    core_key_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("drop_idle_in_ready", 64'(in_ready), 64'd0);
    check("drop_idle_busy", 64'(busy), 64'd0);
    tick();
    check("drop_abort_once", 64'(abort_cnt - a0), 64'd1);
    core_key_ready = 1'b1;
    run_block("after_drop_zero", 1'b0, 64'h0);

    // Key drop while the core is running.
    send_block(1'b1, {$urandom, $urandom});
    repeat (10) tick();
    @(negedge clk);
    check("run_busy", 64'(busy), 64'd1);
    check("run_core_start", 64'(core_start), 64'd1);
    tick();
    a0 = abort_cnt;
    core_key_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("run_drop_abort_once", 64'(abort_cnt - a0), 64'd1);
    check("run_drop_start_low", 64'(core_start), 64'd0);
    check("run_drop_no_output", 64'(out_valid), 64'd0);
    tick();
    core_key_ready = 1'b1;
    run_block("after_run_drop", 1'b0, {$urandom, $urandom});

    // Randomised blocks against the model.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_iv({$urandom, $urandom});
      run_block($sformatf("random%0d", i), 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    // Back-to-back: producer and consumer never stall.
    for (int k = 0; k < 3; k++) begin
      bd[k] = (k == 2) ? {$urandom, $urandom} : 64'h0;
      model_step(1'b0, bd[k], bexp[k]);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) send_block(1'b0, bd[k]);
      end
      begin
        for (int j = 0; j < 3; j++) recv_block(bgot[j]);
      end
    join
    for (int k = 0; k < 3; k++) check($sformatf("b2b%0d", k), bgot[k], bexp[k]);

    // Reset in the middle of a block.
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h3C);
    in_valid = 1'b0;
    a0 = abort_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_core_block", core_block, 64'd0);
    tick();
    rst = 1'b1;
    chain_m = 64'h0;
    tick();
    check("midrst_no_abort", 64'(abort_cnt - a0), 64'd0);
    run_block("after_midrst", 1'b0, {$urandom, $urandom});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
